// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator that bridges a command/stream
// interface onto the venus_soc_pkg request/response channel structs.

package venus_soc_pkg;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_ID_WIDTH   = 4;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]     awid;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awlock;
    logic [3:0]                  awcache;
    logic [2:0]                  awprot;
    logic [3:0]                  awqos;
    logic                        awvalid;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        bready;
    logic [AXI_ID_WIDTH-1:0]     arid;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arlock;
    logic [3:0]                  arcache;
    logic [2:0]                  arprot;
    logic [3:0]                  arqos;
    logic                        arvalid;
    logic                        rready;
  } axi_req_t;

  typedef struct packed {
    logic                        awready;
    logic                        wready;
    logic [AXI_ID_WIDTH-1:0]     bid;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        arready;
    logic [AXI_ID_WIDTH-1:0]     rid;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
  } axi_resp_t;
endpackage

module axi4_burst_master
  import venus_soc_pkg::*;
#(
  parameter int                  DATA_WIDTH    = 64,
  parameter int                  ADDRESS_WIDTH = 32,
  parameter int                  ID_WIDTH      = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID        = '0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr,
  input  logic [7:0]                cmd_len,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic [DATA_WIDTH/8-1:0]   wr_strb,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last,
  output logic                      sts_valid,
  input  logic                      sts_ready,
  output logic [1:0]                sts_resp,
  output logic                      sts_proto_err,
  output axi_req_t                  axi_req_o,
  input  axi_resp_t                 axi_resp_i
);

  localparam int         BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE  = 3'($clog2(BYTES));

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_STS
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [ADDRESS_WIDTH-1:0]   r_addr;
  logic [7:0]                 r_len;
  logic [7:0]                 r_cnt;
  logic [1:0]                 r_resp;
  logic                       r_perr;

  logic [31:0]                w_span;
  logic                       w_cross;
  logic                       w_at_len;
  logic                       w_rhs;
  logic                       w_whs;
  logic [1:0]                 w_rresp;
  logic [1:0]                 w_bresp;
  logic [1:0]                 w_resp_max;
  logic                       w_unused;

  // Byte span of the burst measured from the start of its 4 KB page.
  assign w_span   = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(BYTES);
  assign w_cross  = (w_span > 32'd4096);
  assign w_at_len = (r_cnt == r_len);
  assign w_rhs    = (r_state == S_R) && axi_resp_i.rvalid && rd_ready;
  assign w_whs    = (r_state == S_W) && wr_valid && axi_resp_i.wready;

  // EXOKAY folds to OKAY so that numeric order gives DECERR > SLVERR > OKAY.
  assign w_rresp    = (axi_resp_i.rresp == 2'b01) ? 2'b00 : axi_resp_i.rresp;
  assign w_bresp    = (axi_resp_i.bresp == 2'b01) ? 2'b00 : axi_resp_i.bresp;
  assign w_resp_max = (w_rresp > r_resp) ? w_rresp : r_resp;

  assign sts_resp      = r_resp;
  assign sts_proto_err = r_perr;
  assign w_unused      = ^{axi_resp_i.bid, axi_resp_i.rid};

  always_ff @(posedge aclk) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next                = r_state;
    axi_req_o             = '0;
    axi_req_o.awid        = AXI_ID;
    axi_req_o.awaddr      = r_addr;
    axi_req_o.awlen       = r_len;
    axi_req_o.awsize      = SIZE;
    axi_req_o.awburst     = 2'b01;
    axi_req_o.wdata       = wr_data;
    axi_req_o.wstrb       = wr_strb;
    axi_req_o.arid        = AXI_ID;
    axi_req_o.araddr      = r_addr;
    axi_req_o.arlen       = r_len;
    axi_req_o.arsize      = SIZE;
    axi_req_o.arburst     = 2'b01;
    cmd_ready             = 1'b0;
    wr_ready              = 1'b0;
    rd_valid              = 1'b0;
    rd_data               = axi_resp_i.rdata;
    rd_last               = 1'b0;
    sts_valid             = 1'b0;

    case (r_state)
      S_IDLE: begin
        cmd_ready = !areset;
        if (cmd_valid && !areset) begin
          if (w_cross)        w_next = S_STS;
          else if (cmd_write) w_next = S_AW;
          else                w_next = S_AR;
        end
      end
      S_AR: begin
        axi_req_o.arvalid = 1'b1;
        if (axi_resp_i.arready) w_next = S_R;
      end
      S_R: begin
        axi_req_o.rready = rd_ready;
        rd_valid         = axi_resp_i.rvalid;
        rd_last          = axi_resp_i.rlast;
        if (w_rhs && (axi_resp_i.rlast || w_at_len)) w_next = S_STS;
      end
      S_AW: begin
        axi_req_o.awvalid = 1'b1;
        if (axi_resp_i.awready) w_next = S_W;
      end
      S_W: begin
        axi_req_o.wvalid = wr_valid;
        axi_req_o.wlast  = w_at_len;
        wr_ready         = axi_resp_i.wready;
        if (w_whs && w_at_len) w_next = S_B;
      end
      S_B: begin
        axi_req_o.bready = 1'b1;
        if (axi_resp_i.bvalid) w_next = S_STS;
      end
      S_STS: begin
        sts_valid = 1'b1;
        if (sts_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, beat counter and the sticky worst-case response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_resp <= 2'b00;
      r_perr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr <= cmd_addr;
            r_len  <= cmd_len;
            r_cnt  <= '0;
            r_resp <= w_cross ? 2'b10 : 2'b00;
            r_perr <= w_cross;
          end
        end
        S_R: begin
          if (w_rhs) begin
            r_resp <= w_resp_max;
            if (axi_resp_i.rlast != w_at_len) r_perr <= 1'b1;
            if (!axi_resp_i.rlast && !w_at_len) r_cnt <= r_cnt + 8'd1;
          end
        end
        S_W: begin
          if (w_whs && !w_at_len) r_cnt <= r_cnt + 8'd1;
        end
        S_B: begin
          if (axi_resp_i.bvalid) r_resp <= w_bresp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Self-checking bench for axi4_burst_master: the bench plays the AXI slave and
// the stream endpoints, and predicts status from per-burst response rules.

module tb_axi4_burst_master;
  import venus_soc_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        rd_valid;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        rd_last;
  logic        sts_valid;
  logic        sts_ready;
  logic [1:0]  sts_resp;
  logic        sts_proto_err;
  axi_req_t    axiReq;
  axi_resp_t   axiResp;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [63:0] beatData [256];
  logic [7:0]  beatStrb [256];
  logic [1:0]  beatResp [256];

  always #5 aclk = ~aclk;

  axi4_burst_master #(
    .DATA_WIDTH(64), .ADDRESS_WIDTH(32), .ID_WIDTH(4), .AXI_ID(4'd0)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_resp(sts_resp),
    .sts_proto_err(sts_proto_err),
    .axi_req_o(axiReq), .axi_resp_i(axiResp)
  );

  // Severity ranking of AXI responses; EXOKAY counts as OKAY.
  function automatic int respRank(input logic [1:0] r);
    case (r)
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] rankResp(input int k);
    case (k)
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic fillBeats(input int len);
    for (int k = 0; k <= len; k++) begin
      beatData[k] = {$urandom, $urandom};
      beatStrb[k] = 8'($urandom);
      beatResp[k] = 2'b00;
    end
  endtask

  task automatic issueCmd(input logic w, input logic [31:0] a, input logic [7:0] l,
                          output bit ok);
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    @(posedge aclk);
    #1;
    cmd_valid = 1'b0;
    nCompared++;
    if (!ok) begin
      nMismatched++;
      $display("[TB] FAIL cmd_accept: cmd_ready never 1 within 20 cycles, wanted 1");
    end
  endtask

  task automatic finish_status(input logic [1:0] expResp, input logic expPerr, input string tag);
    bit hs;
    #1;
    nCompared++;
    if (sts_valid !== 1'b1 || sts_resp !== expResp || sts_proto_err !== expPerr || cmd_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s_status: valid=%0b resp=%b proto_err=%0b cmd_ready=%0b, wanted 1 %b %0b 0",
               tag, sts_valid, sts_resp, sts_proto_err, cmd_ready, expResp, expPerr);
    end
    hs = 1'b0;
    for (int t = 0; t < 20 && !hs; t++) begin
      sts_ready = (t > 2) || ($urandom_range(0, 1) == 1);
      #1;
      hs = sts_valid && sts_ready;
      @(negedge aclk);
      sts_ready = 1'b0;
    end
    #1;
    nCompared++;
    if (!hs || sts_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL %s_release: handshake=%0b sts_valid=%0b cmd_ready=%0b, wanted 1 0 1",
               tag, hs, sts_valid, cmd_ready);
    end
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [7:0] len,
                          input int lastBeat, input bit stall);
    bit   ok, hs;
    int   beats, worst, i;
    logic expPerr;
    // The burst ends on the first of: rlast seen, or len+1 beats accepted.
    beats   = (lastBeat < int'(len)) ? lastBeat + 1 : int'(len) + 1;
    worst   = 0;
    for (int k = 0; k < beats; k++)
      if (respRank(beatResp[k]) > worst) worst = respRank(beatResp[k]);
    expPerr = (lastBeat != int'(len));

    issueCmd(1'b0, addr, len, ok);
    if (!ok) return;
    @(negedge aclk);
    #1;
    nCompared++;
    if (axiReq.arvalid !== 1'b1 || axiReq.araddr !== addr || axiReq.arlen !== len ||
        axiReq.arsize !== 3'd3 || axiReq.arburst !== 2'b01 || axiReq.arid !== 4'd0 ||
        axiReq.awvalid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ar_request: arvalid=%0b araddr=%h arlen=%0d arsize=%0d arburst=%b, wanted 1 %h %0d 3 01",
               axiReq.arvalid, axiReq.araddr, axiReq.arlen, axiReq.arsize, axiReq.arburst, addr, len);
    end
    hs = 1'b0;
    for (int t = 0; t < 40 && !hs; t++) begin
      axiResp.arready = (t > 4) || ($urandom_range(0, 2) == 0);
      #1;
      hs = axiReq.arvalid && axiResp.arready;
      @(negedge aclk);
      axiResp.arready = 1'b0;
    end
    nCompared++;
    if (!hs) begin
      nMismatched++;
      $display("[TB] FAIL ar_handshake: no handshake within 40 cycles, wanted one");
      return;
    end
    i = 0;
    for (int t = 0; t < 3000 && i < beats; t++) begin
      axiResp.rvalid = (t == 0) || ($urandom_range(0, 3) != 0);
      axiResp.rdata  = beatData[i];
      axiResp.rresp  = beatResp[i];
      axiResp.rlast  = (i == lastBeat);
      rd_ready       = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (t == 0 && !stall) begin
        nCompared++;
        if (axiReq.rready !== 1'b1) begin
          nMismatched++;
          $display("[TB] FAIL r_latency: rready=%0b one cycle after AR handshake, wanted 1", axiReq.rready);
        end
      end
      if (axiResp.rvalid && axiReq.rready) begin
        nCompared++;
        if (rd_ready !== 1'b1 || rd_valid !== 1'b1 || rd_data !== beatData[i] ||
            rd_last !== (i == lastBeat) || cmd_ready !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL rd_beat%0d: rd_ready=%0b rd_valid=%0b rd_data=%h rd_last=%0b cmd_ready=%0b, wanted 1 1 %h %0b 0",
                   i, rd_ready, rd_valid, rd_data, rd_last, cmd_ready, beatData[i], (i == lastBeat));
        end
        i++;
      end
      @(negedge aclk);
      axiResp.rvalid = 1'b0;
      axiResp.rlast  = 1'b0;
      rd_ready       = 1'b0;
    end
    nCompared++;
    if (i != beats) begin
      nMismatched++;
      $display("[TB] FAIL rd_count: %0d beats accepted, wanted %0d", i, beats);
      return;
    end
    finish_status(rankResp(worst), expPerr, "read");
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] bresp, input bit stall);
    bit ok, hs, earlyW;
    int i;
    issueCmd(1'b1, addr, len, ok);
    if (!ok) return;
    wr_valid       = 1'b1;
    wr_data        = beatData[0];
    wr_strb        = beatStrb[0];
    axiResp.wready = 1'b1;
    @(negedge aclk);
    #1;
    nCompared++;
    if (axiReq.awvalid !== 1'b1 || axiReq.awaddr !== addr || axiReq.awlen !== len ||
        axiReq.awsize !== 3'd3 || axiReq.awburst !== 2'b01 || axiReq.arvalid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL aw_request: awvalid=%0b awaddr=%h awlen=%0d awsize=%0d awburst=%b, wanted 1 %h %0d 3 01",
               axiReq.awvalid, axiReq.awaddr, axiReq.awlen, axiReq.awsize, axiReq.awburst, addr, len);
    end
    hs     = 1'b0;
    earlyW = 1'b0;
    for (int t = 0; t < 40 && !hs; t++) begin
      axiResp.awready = (t > 4) || ($urandom_range(0, 2) == 0);
      #1;
      if (axiReq.wvalid || wr_ready) earlyW = 1'b1;
      hs = axiReq.awvalid && axiResp.awready;
      @(negedge aclk);
      axiResp.awready = 1'b0;
    end
    nCompared++;
    if (!hs || earlyW) begin
      nMismatched++;
      $display("[TB] FAIL aw_handshake: handshake=%0b early_w=%0b, wanted 1 0", hs, earlyW);
      return;
    end
    i = 0;
    for (int t = 0; t < 3000 && i <= int'(len); t++) begin
      wr_valid       = stall ? (t % 2 == 0) : ($urandom_range(0, 3) != 0);
      wr_data        = beatData[i];
      wr_strb        = beatStrb[i];
      axiResp.wready = stall ? (t % 3 != 1) : ($urandom_range(0, 3) != 0);
      #1;
      if (axiReq.wvalid && axiResp.wready) begin
        nCompared++;
        if (wr_ready !== 1'b1 || wr_valid !== 1'b1 || axiReq.wdata !== beatData[i] ||
            axiReq.wstrb !== beatStrb[i] || axiReq.wlast !== (i == int'(len))) begin
          nMismatched++;
          $display("[TB] FAIL w_beat%0d: wr_ready=%0b wdata=%h wstrb=%h wlast=%0b, wanted 1 %h %h %0b",
                   i, wr_ready, axiReq.wdata, axiReq.wstrb, axiReq.wlast, beatData[i], beatStrb[i], (i == int'(len)));
        end
        i++;
      end
      @(negedge aclk);
    end
    nCompared++;
    if (i != int'(len) + 1) begin
      nMismatched++;
      $display("[TB] FAIL w_count: %0d handshakes, wanted %0d", i, int'(len) + 1);
      wr_valid = 1'b0;
      return;
    end
    hs = 1'b0;
    for (int t = 0; t < 40 && !hs; t++) begin
      wr_valid       = 1'b1;
      axiResp.wready = 1'b1;
      axiResp.bvalid = (t > 3) || ($urandom_range(0, 1) == 1);
      axiResp.bresp  = bresp;
      #1;
      if (t == 0) begin
        nCompared++;
        if (axiReq.wvalid !== 1'b0 || wr_ready !== 1'b0 || axiReq.bready !== 1'b1) begin
          nMismatched++;
          $display("[TB] FAIL w_extra: wvalid=%0b wr_ready=%0b bready=%0b after last beat, wanted 0 0 1",
                   axiReq.wvalid, wr_ready, axiReq.bready);
        end
      end
      hs = axiResp.bvalid && axiReq.bready;
      @(negedge aclk);
      axiResp.bvalid = 1'b0;
    end
    wr_valid       = 1'b0;
    axiResp.wready = 1'b0;
    nCompared++;
    if (!hs) begin
      nMismatched++;
      $display("[TB] FAIL b_handshake: none within 40 cycles, wanted one");
      return;
    end
    finish_status(rankResp(respRank(bresp)), 1'b0, "write");
  endtask

  task automatic run_reject(input logic w, input logic [31:0] addr, input logic [7:0] len);
    bit ok;
    issueCmd(w, addr, len, ok);
    if (!ok) return;
    @(negedge aclk);
    #1;
    nCompared++;
    if (axiReq.arvalid !== 1'b0 || axiReq.awvalid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reject_no_axi: arvalid=%0b awvalid=%0b, wanted 0 0", axiReq.arvalid, axiReq.awvalid);
    end
    finish_status(2'b10, 1'b1, "reject");
  endtask

  task automatic test_reset();
    areset    = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid  = 1'b0; wr_data = '0; wr_strb = '0;
    rd_ready  = 1'b0; sts_ready = 1'b0;
    axiResp   = '0;
    repeat (3) @(negedge aclk);
    #1;
    nCompared++;
    if (cmd_ready !== 1'b0 || axiReq.arvalid !== 1'b0 || axiReq.awvalid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_hold: cmd_ready=%0b arvalid=%0b awvalid=%0b, wanted 0 0 0",
               cmd_ready, axiReq.arvalid, axiReq.awvalid);
    end
    @(negedge aclk);
    areset = 1'b0;
    #1;
    nCompared++;
    if (cmd_ready !== 1'b1 || sts_valid !== 1'b0 || sts_resp !== 2'b00 || sts_proto_err !== 1'b0 ||
        wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || axiReq.wvalid !== 1'b0 ||
        axiReq.bready !== 1'b0 || axiReq.rready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_idle: cmd_ready=%0b sts_valid=%0b resp=%b perr=%0b wr_ready=%0b rd_valid=%0b, wanted 1 0 00 0 0 0",
               cmd_ready, sts_valid, sts_resp, sts_proto_err, wr_ready, rd_valid);
    end
  endtask

  task automatic test_read_basic();
    fillBeats(3);
    run_read(32'h0000_0100, 8'd3, 3, 1'b0);
    fillBeats(0);
    run_read(32'h0000_0040, 8'd0, 0, 1'b1);
  endtask

  task automatic test_write_stall();
    fillBeats(7);
    run_write(32'h0000_0200, 8'd7, 2'b00, 1'b1);
  endtask

  task automatic test_error_resp();
    fillBeats(1);
    beatResp[0] = 2'b10;
    run_read(32'h0000_0500, 8'd1, 1, 1'b0);
    fillBeats(3);
    beatResp[1] = 2'b11; beatResp[2] = 2'b01; beatResp[3] = 2'b10;
    run_read(32'h0000_0600, 8'd3, 3, 1'b1);
    fillBeats(0);
    beatResp[0] = 2'b01;
    run_read(32'h0000_0700, 8'd0, 0, 1'b0);
    fillBeats(2);
    run_write(32'h0000_0800, 8'd2, 2'b11, 1'b0);
    fillBeats(0);
    run_write(32'h0000_0900, 8'd0, 2'b10, 1'b0);
  endtask

  task automatic test_rlast_early();
    fillBeats(3);
    run_read(32'h0000_0A00, 8'd3, 1, 1'b0);
    fillBeats(2);
    run_read(32'h0000_0B00, 8'd2, 300, 1'b0);
  endtask

  task automatic test_boundary();
    run_reject(1'b0, 32'h0000_0FF8, 8'd1);
    run_reject(1'b1, 32'h0000_1FF8, 8'd1);
    run_reject(1'b0, 32'h0000_0900, 8'd255);
    fillBeats(1);
    run_read(32'h0000_0FF0, 8'd1, 1, 1'b0);
  endtask

  task automatic test_reset_midburst();
    bit ok;
    int i;
    fillBeats(5);
    issueCmd(1'b1, 32'h0000_0300, 8'd5, ok);
    if (!ok) return;
    axiResp.awready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    axiResp.awready = 1'b0;
    i = 0;
    for (int t = 0; t < 20 && i < 2; t++) begin
      wr_valid       = 1'b1;
      wr_data        = beatData[i];
      wr_strb        = beatStrb[i];
      axiResp.wready = 1'b1;
      #1;
      if (axiReq.wvalid && axiResp.wready) i++;
      @(negedge aclk);
    end
    wr_data = beatData[2];
    areset  = 1'b1;
    #1;
    nCompared++;
    if (i != 2 || cmd_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midburst_setup: beats=%0d cmd_ready=%0b, wanted 2 0", i, cmd_ready);
    end
    @(negedge aclk);
    areset  = 1'b0;
    axiResp = '0;
    #1;
    nCompared++;
    if (axiReq.awvalid !== 1'b0 || axiReq.wvalid !== 1'b0 || axiReq.arvalid !== 1'b0 ||
        axiReq.bready !== 1'b0 || axiReq.rready !== 1'b0 || wr_ready !== 1'b0 ||
        rd_valid !== 1'b0 || sts_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL midburst_abort: awv=%0b wv=%0b arv=%0b bready=%0b wr_ready=%0b sts_valid=%0b cmd_ready=%0b, wanted 0 0 0 0 0 0 1",
               axiReq.awvalid, axiReq.wvalid, axiReq.arvalid, axiReq.bready, wr_ready, sts_valid, cmd_ready);
    end
    repeat (4) @(negedge aclk);
    #1;
    nCompared++;
    if (sts_valid !== 1'b0 || wr_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL midburst_quiet: sts_valid=%0b wr_ready=%0b, wanted 0 0", sts_valid, wr_ready);
    end
    wr_valid = 1'b0;
    fillBeats(0);
    run_read(32'h0000_0400, 8'd0, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [11:0] off;
    int          len, lastBeat;
    bit          isWrite;
    for (int n = 0; n < 30; n++) begin
      len     = $urandom_range(0, 15);
      isWrite = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) off = 12'(4096 - 8 * $urandom_range(1, 20));
      else                           off = 12'(8 * $urandom_range(0, 511));
      addr = ($urandom & 32'hFFFF_F000) | {20'd0, off};
      fillBeats(len);
      if (int'(off) + (len + 1) * 8 > 4096) begin
        run_reject(isWrite, addr, 8'(len));
      end else if (isWrite) begin
        run_write(addr, 8'(len), 2'($urandom), ($urandom_range(0, 1) == 1));
      end else begin
        for (int k = 0; k <= len; k++)
          if ($urandom_range(0, 5) == 0) beatResp[k] = 2'($urandom);
        lastBeat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len;
        run_read(addr, 8'(len), lastBeat, ($urandom_range(0, 1) == 1));
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_error_resp();
    test_rlast_early();
    test_boundary();
    test_reset_midburst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- Single-outstanding AXI4 initiator. Turns a simple command/stream interface into INCR bursts on a venus_soc_pkg axi_req_t/axi_resp_t port pair.
- It is the master counterpart of the memory responder wrapper. DMA engines and testbench traffic sources use it to drive any AXI4 slave, including the RAM/ROM model.
- Write data enters on a stream port, read data leaves on a stream port, and one status word is returned per command.

Parameters:
- DATA_WIDTH, 64, AXI data width in bits (power of two, 32..512).
- ADDRESS_WIDTH, 32, AXI address width in bits.
- ID_WIDTH, 4, width of the ID field driven on AW/AR.
- AXI_ID, 0, constant ID driven on awid/arid. BID/RID are not checked.

Ports:
- aclk  input  1  clock.
- areset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command valid.
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  ADDRESS_WIDTH  start byte address.
- cmd_len  input  8  beats minus 1 (AXI4 awlen/arlen encoding, 0..255).
- wr_valid  input  1  write data beat valid.
- wr_ready  output  1  write data beat accepted.
- wr_data  input  DATA_WIDTH  write data.
- wr_strb  input  DATA_WIDTH/8  write byte strobes.
- rd_valid  output  1  read data beat valid.
- rd_ready  input  1  read data beat accepted.
- rd_data  output  DATA_WIDTH  read data.
- rd_last  output  1  final beat of the read burst.
- sts_valid  output  1  completion status valid, one pulse per command, held until sts_ready.
- sts_ready  input  1  status accepted.
- sts_resp  output  2  worst AXI response of the burst (OKAY=00, SLVERR=10, DECERR=11).
- sts_proto_err  output  1  rlast mismatch, or command rejected for crossing a 4 KB boundary.
- axi_req_o  output  axi_req_t  AXI request channels.
- axi_resp_i  input  axi_resp_t  AXI response channels.

Behaviour:
- Interface decision: one clock aclk; reset areset is synchronous and active-high.
- Reset values:
  - All AXI valids 0; bready 0; rready 0.
  - cmd_ready 0 during reset, 1 in IDLE afterwards.
  - wr_ready, rd_valid, rd_last and sts_valid are 0.
  - sts_resp is 00; sts_proto_err is 0; beat counter is 0.
- Fixed AXI fields: size = log2(DATA_WIDTH/8); burst = INCR (01); lock, cache, prot, qos = 0; id = AXI_ID.
- States are IDLE, AR, R, AW, W, B, STS.
- IDLE: cmd_ready=1. On accept, latch addr and len, clear the beat counter and the sticky response.
  - Boundary check: if (cmd_addr[11:0] + (cmd_len+1)*DATA_WIDTH/8) > 4096, go to STS with sts_proto_err=1 and sts_resp=10. No AXI traffic is issued.
  - Otherwise a write goes to AW and a read goes to AR.
- AR: arvalid=1 with latched fields, held stable until arready. The cycle after the handshake enters R.
- R: rready = rd_ready. rd_valid = rvalid, rd_data = rdata, rd_last = rlast (combinational pass-through, zero-latency).
  - Per accepted beat: update the sticky response as the max of the current value and rresp, where DECERR > SLVERR > OKAY (EXOKAY is treated as OKAY).
  - When rlast is seen with counter != len, set proto_err and go to STS.
  - When counter == len without rlast, set proto_err; that beat also ends the burst and goes to STS.
  - Normal end is rlast at counter == len, then STS.
- AW: awvalid=1 until awready, then enter W. No W beat is issued before the AW handshake.
- W: wvalid = wr_valid, wr_ready = wready, wdata/wstrb pass through. wlast=1 exactly when counter == len.
  - The counter increments on each wvalid & wready.
  - On the last handshake go to B. wr_ready is 0 in every other state.
- B: bready=1. On bvalid, capture bresp and go to STS.
- STS: sts_valid=1 holding resp/proto_err; go to IDLE on sts_ready. A new command is accepted no earlier than the cycle after the status handshake.
- Counter is 8 bits and never wraps past len.
- Minimum latency:
  - len=0 read: cmd accept to arvalid is 1 cycle; arready to R is 1 cycle.
  - Status asserts the cycle after the last R/B handshake.
- Reset mid-burst: the next cycle all valids/readies drop and the FSM returns to IDLE. No status is emitted and pending stream data is discarded. The slave side must also be reset.
- Simultaneous events:
  - cmd_valid during a non-IDLE state is ignored (cmd_ready=0).
  - A status handshake and a new cmd_valid in the same cycle: the command waits one cycle.

Test Plan:
- Read addr 0x100, len=3, slave returns 4 OKAY beats with rlast on beat 3 -> araddr=0x100, arlen=3, arsize=3 (64-bit); 4 rd beats with rd_last on the 4th; sts_resp=00, proto_err=0.
- Write addr 0x200, len=7, wr_valid stalled every other cycle, slave wready toggling -> exactly 8 W handshakes, wlast only on the 8th, AW before the first W; bresp=00 gives sts_resp=00.
- Read len=1, slave returns SLVERR on beat 0 and OKAY on beat 1 -> sts_resp=10; write where bresp=11 -> sts_resp=11.
- Read len=3, slave asserts rlast on beat 1 -> sts_proto_err=1 and the FSM returns to IDLE after sts_ready.
- Command addr 0xFF8, len=1 (64-bit beats, crosses 4 KB) -> no arvalid/awvalid ever; sts_valid with proto_err=1, resp=10.
- areset asserted on W beat 2 of len=5, then a fresh read len=0 -> all valids 0 the cycle after reset; no status from the aborted command; the new read completes with sts_resp=00.
